// File: rtl/xilly_stream_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : xilly_stream_pkg
//  Description : Shared types and limits for the Xillybus stream FIFO blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package xilly_stream_pkg;

  // Session state of a write/read stream pair.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    EOF    = 2'd3
  } xs_state_t;

  // Supported parameter limits.
  localparam int XS_MAX_DATA_W = 64;
  localparam int XS_MAX_ADDR_W = 12;

endpackage
`default_nettype wire

// File: rtl/xilly_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module      : xilly_sdp_ram
//  Description : Simple dual-port RAM, one write port and one registered read
//                port. The array has no reset; only the read register does.
//  Revision    : 1.0 - initial release
// ============================================================================
module xilly_sdp_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Store the incoming word.
  always_ff @(posedge bus_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register holds its value unless a read is accepted.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/xilly_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : xilly_loopback_fifo
//  Description : Stream FIFO joining a Xillybus host-to-FPGA write stream to an
//                FPGA-to-host read stream, with EOF signalling on writer close,
//                flush when both ends close, fill level and sticky errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module xilly_loopback_fifo #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 9,
  parameter int FULL_MARGIN = 1
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  input  logic              user_w_open,
  input  logic              user_r_rden,
  output logic [DATA_W-1:0] user_r_data,
  output logic              user_r_empty,
  output logic              user_r_eof,
  input  logic              user_r_open,
  output logic [ADDR_W:0]   fill,
  output logic              overflow,
  output logic              underflow
);

  import xilly_stream_pkg::*;

  localparam int              DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_W    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W+1)'(DEPTH - FULL_MARGIN);

  logic [ADDR_W:0] wp, rp;
  logic [ADDR_W:0] wp_next, rp_next;
  logic [ADDR_W:0] fill_cur, fill_next;
  xs_state_t       st, st_next;
  logic            flush, wr_allowed, wr_acc, rd_acc, ovf_set, unf_set;

  // Accept/drop decisions, next pointers and next session state.
  always_comb begin
    fill_cur   = wp - rp;
    // Both ends closed with data left: nobody will ever read it, discard.
    flush      = !user_w_open && !user_r_open && (fill_cur != '0);
    // Once the writer has closed, late writes must not disturb the EOF.
    wr_allowed = (st == IDLE) || (st == STREAM);
    wr_acc     = !flush && wr_allowed && user_w_wren && (fill_cur < DEPTH_W);
    ovf_set    = !flush && wr_allowed && user_w_wren && (fill_cur >= DEPTH_W);
    rd_acc     = !flush && user_r_rden && (fill_cur != '0);
    unf_set    = !flush && user_r_rden && (fill_cur == '0);

    wp_next    = wp + {{ADDR_W{1'b0}}, wr_acc};
    rp_next    = flush ? wp : (rp + {{ADDR_W{1'b0}}, rd_acc});
    fill_next  = wp_next - rp_next;

    st_next = st;
    if (flush) begin
      st_next = IDLE;
    end else begin
      case (st)
        IDLE:    if (user_w_open) st_next = STREAM;
        STREAM:  if (!user_w_open) st_next = DRAIN;
        DRAIN: begin
          if (user_w_open)            st_next = STREAM;
          else if (fill_next == '0)   st_next = EOF;
        end
        EOF: begin
          if (user_w_open)            st_next = STREAM;
          else if (!user_r_open)      st_next = IDLE;
        end
        default:                      st_next = IDLE;
      endcase
    end
  end

  // Pointer and state registers.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      wp <= '0;
      rp <= '0;
      st <= IDLE;
    end else begin
      wp <= wp_next;
      rp <= rp_next;
      st <= st_next;
    end
  end

  // Status flags are registered from next-state values so they are valid
  // in the cycle right after the edge that changed them.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      user_r_empty <= 1'b1;
      user_w_full  <= 1'b0;
      user_r_eof   <= 1'b0;
      fill         <= '0;
    end else begin
      user_r_empty <= (fill_next == '0);
      user_w_full  <= (fill_next >= FULL_LEVEL);
      user_r_eof   <= (st_next == EOF);
      fill         <= fill_next;
    end
  end

  // Sticky error flags, cleared only by a flush or reset.
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set) overflow  <= 1'b1;
      if (unf_set) underflow <= 1'b1;
    end
  end

  xilly_sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .bus_clk (bus_clk),
    .bus_rst (bus_rst),
    .wr_en   (wr_acc),
    .wr_addr (wp[ADDR_W-1:0]),
    .wr_data (user_w_data),
    .rd_en   (rd_acc),
    .rd_addr (rp[ADDR_W-1:0]),
    .rd_data (user_r_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_xilly_loopback_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_xilly_loopback_fifo
//  Description : Self-checking bench: directed scenarios plus random traffic
//                against a queue-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_xilly_loopback_fifo;

  localparam int DEPTH_A  = 16;
  localparam int MARGIN_A = 1;

  logic clk = 1'b0;
  logic rst;

  // Instance A: 32-bit wide, 16 deep
  logic        a_wren, a_wopen, a_rden, a_ropen;
  logic [31:0] a_wdata, a_rdata;
  logic        a_full, a_empty, a_eof, a_ovf, a_unf;
  logic [4:0]  a_fill;

  // Instance B: 8-bit wide, 4 deep
  logic        b_wren, b_wopen, b_rden, b_ropen;
  logic [7:0]  b_wdata, b_rdata;
  logic        b_full, b_empty, b_eof, b_ovf, b_unf;
  logic [2:0]  b_fill;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model for instance A
  logic [31:0] mq[$];
  int          mst;      // 0 idle, 1 stream, 2 drain, 3 eof
  logic        m_ovf, m_unf;
  logic [31:0] m_data;

  xilly_loopback_fifo #(.DATA_W(32), .ADDR_W(4), .FULL_MARGIN(MARGIN_A)) dut_a (
    .bus_clk(clk), .bus_rst(rst),
    .user_w_wren(a_wren), .user_w_data(a_wdata), .user_w_full(a_full),
    .user_w_open(a_wopen), .user_r_rden(a_rden), .user_r_data(a_rdata),
    .user_r_empty(a_empty), .user_r_eof(a_eof), .user_r_open(a_ropen),
    .fill(a_fill), .overflow(a_ovf), .underflow(a_unf)
  );

  xilly_loopback_fifo #(.DATA_W(8), .ADDR_W(2), .FULL_MARGIN(1)) dut_b (
    .bus_clk(clk), .bus_rst(rst),
    .user_w_wren(b_wren), .user_w_data(b_wdata), .user_w_full(b_full),
    .user_w_open(b_wopen), .user_r_rden(b_rden), .user_r_data(b_rdata),
    .user_r_empty(b_empty), .user_r_eof(b_eof), .user_r_open(b_ropen),
    .fill(b_fill), .overflow(b_ovf), .underflow(b_unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst    = 0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_data = '0;
  endtask

  // One clock edge of the FIFO rules, in terms of a word queue.
  task automatic model_edge();
    int sz;
    if (rst) begin
      model_reset();
      return;
    end
    sz = mq.size();
    if (!a_wopen && !a_ropen && sz > 0) begin
      mq.delete();
      mst   = 0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    if (a_rden) begin
      if (sz > 0) m_data = mq.pop_front();
      else        m_unf  = 1'b1;
    end
    if (a_wren && (mst == 0 || mst == 1)) begin
      if (sz < DEPTH_A) mq.push_back(a_wdata);
      else              m_ovf = 1'b1;
    end
    case (mst)
      0: if (a_wopen) mst = 1;
      1: if (!a_wopen) mst = 2;
      2: if (a_wopen) mst = 1; else if (mq.size() == 0) mst = 3;
      3: if (a_wopen) mst = 1; else if (!a_ropen) mst = 0;
      default: mst = 0;
    endcase
  endtask

  task automatic check_all();
    chk("fill",      64'(a_fill),  64'(mq.size()));
    chk("empty",     64'(a_empty), 64'(mq.size() == 0));
    chk("full",      64'(a_full),  64'(mq.size() >= DEPTH_A - MARGIN_A));
    chk("eof",       64'(a_eof),   64'(mst == 3));
    chk("data",      64'(a_rdata), 64'(m_data));
    chk("overflow",  64'(a_ovf),   64'(m_ovf));
    chk("underflow", 64'(a_unf),   64'(m_unf));
  endtask

  // Advance one clock; inputs are changed only after this returns.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic write_a(input logic [31:0] v);
    a_wren = 1'b1; a_wdata = v;
    cyc();
    a_wren = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_wren = 0; a_wopen = 0; a_rden = 0; a_ropen = 0; a_wdata = '0;
    b_wren = 0; b_wopen = 0; b_rden = 0; b_ropen = 0; b_wdata = '0;
    model_reset();
    cyc(); cyc();
    chk("rst_fill",  64'(a_fill),  64'd0);
    chk("rst_empty", 64'(a_empty), 64'd1);
    chk("rst_data",  64'(a_rdata), 64'd0);
    chk("rst_full",  64'(a_full),  64'd0);
    rst = 1'b0;

    // In-order transfer of three words
    a_wopen = 1; a_ropen = 1;
    cyc();
    write_a(32'h11); write_a(32'h22); write_a(32'h33);
    a_rden = 1;
    cyc(); chk("t1_d0", 64'(a_rdata), 64'h11);
    cyc(); chk("t1_d1", 64'(a_rdata), 64'h22);
    cyc(); chk("t1_d2", 64'(a_rdata), 64'h33);
    chk("t1_empty", 64'(a_empty), 64'd1);
    a_rden = 0;

    // Full threshold and overflow on the 4-deep instance
    b_wopen = 1; b_ropen = 1;
    cyc();
    for (int i = 1; i <= 5; i++) begin
      b_wren = 1; b_wdata = 8'(i);
      cyc();
      if (i == 2) chk("t2_full_at2", 64'(b_full), 64'd0);
      if (i == 3) chk("t2_full_at3", 64'(b_full), 64'd1);
      if (i == 4) chk("t2_fill_at4", 64'(b_fill), 64'd4);
      if (i == 4) chk("t2_ovf_at4",  64'(b_ovf),  64'd0);
    end
    b_wren = 0;
    chk("t2_ovf",  64'(b_ovf),  64'd1);
    chk("t2_fill", 64'(b_fill), 64'd4);

    // Writer close, drain, EOF, reopen
    for (int i = 0; i < 5; i++) write_a(32'h100 + 32'(i));
    a_wopen = 0;
    cyc();
    a_rden = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_data", 64'(a_rdata), 64'(32'h100 + 32'(i)));
      if (i < 4) chk("t3_eof_low", 64'(a_eof), 64'd0);
    end
    a_rden = 0;
    chk("t3_eof",   64'(a_eof),   64'd1);
    chk("t3_empty", 64'(a_empty), 64'd1);
    a_wopen = 1;
    cyc();
    chk("t3_reopen_eof", 64'(a_eof), 64'd0);

    // Simultaneous read/write at fill 2, wrapping many times
    write_a(32'd0); write_a(32'd1);
    for (int k = 2; k < 102; k++) begin
      a_wren = 1; a_wdata = 32'(k); a_rden = 1;
      cyc();
      chk("t4_data", 64'(a_rdata), 64'(k - 2));
      chk("t4_fill", 64'(a_fill),  64'd2);
    end
    a_wren = 0;
    chk("t4_ovf", 64'(a_ovf), 64'd0);
    chk("t4_unf", 64'(a_unf), 64'd0);
    cyc(); cyc();
    a_rden = 0;

    // Underflow, then flush on both ends closed
    a_rden = 1;
    cyc();
    a_rden = 0;
    chk("t5_unf_set", 64'(a_unf), 64'd1);
    for (int i = 0; i < 7; i++) write_a($urandom);
    chk("t5_fill7", 64'(a_fill), 64'd7);
    a_wopen = 0; a_ropen = 0;
    cyc();
    chk("t5_fill",  64'(a_fill),  64'd0);
    chk("t5_empty", 64'(a_empty), 64'd1);
    chk("t5_unf",   64'(a_unf),   64'd0);
    chk("t5_state", 64'(dut_a.st), 64'd0);

    // Asynchronous reset in the middle of a burst
    a_wopen = 1; a_ropen = 1;
    cyc();
    for (int i = 0; i < 10; i++) write_a($urandom);
    chk("t6_fill10", 64'(a_fill), 64'd10);
    a_wren = 1; a_wdata = 32'hDEAD_BEEF;
    rst = 1;
    #1;
    model_reset();
    check_all();
    chk("t6_rst_fill",  64'(a_fill),  64'd0);
    chk("t6_rst_empty", 64'(a_empty), 64'd1);
    chk("t6_rst_data",  64'(a_rdata), 64'd0);
    a_wren = 0;
    cyc();
    rst = 0;
    cyc();
    write_a(32'hA5A5_A5A5);
    a_rden = 1;
    cyc();
    a_rden = 0;
    chk("t6_roundtrip", 64'(a_rdata), 64'hA5A5_A5A5);

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      a_wopen = ($urandom_range(0, 24) != 0);
      a_ropen = ($urandom_range(0, 39) != 0);
      a_wren  = ($urandom_range(0, 2) != 0);
      a_rden  = ($urandom_range(0, 1) != 0);
      a_wdata = $urandom;
      cyc();
    end
    a_wren = 0; a_rden = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
